stim_sequencer: RTL and testbench

// Synthesizable, parametrised stimulus sequencer that replays a loaded program of opcode words and drives
// a packed stimulus bus plus an observation strobe into a DUT. Successor to the fixed per-cycle drive

---
 rtl/stim_sequencer.sv | 209 ++++++++++++++++++++
 tb/tb_stim_sequencer.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stim_sequencer.sv
// Program-driven stimulus sequencer: replays DRIVE/WAIT/LOOP/HALT words onto a registered stimulus bus.
// Define STIM_TRACE_EN to add the trace_vld_o/trace_pc_o retirement trace outputs.
module stim_sequencer #(
  parameter int unsigned OUT_W = 16,
  parameter int unsigned DEPTH = 32,
  parameter int unsigned CNT_W = 8
) (
  input  logic                     wb_clk_i,
  input  logic                     rst_i,
  input  logic                     ld_we_i,
  input  logic [$clog2(DEPTH)-1:0] ld_addr_i,
  input  logic [OUT_W+2:0]         ld_data_i,
  input  logic                     start_i,
  input  logic                     stop_i,
  output logic [OUT_W-1:0]         stim_o,
  output logic                     obs_o,
  output logic [$clog2(DEPTH)-1:0] pc_o,
  output logic                     busy_o,
  output logic                     done_o
`ifdef STIM_TRACE_EN
  ,
  output logic                     trace_vld_o,
  output logic [$clog2(DEPTH)-1:0] trace_pc_o
`endif
);

  localparam int unsigned ADDR_W = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] AddrMax = ADDR_W'(DEPTH - 1);

  localparam logic [1:0] OpDrive = 2'b00;
  localparam logic [1:0] OpWait  = 2'b01;
  localparam logic [1:0] OpLoop  = 2'b10;
  localparam logic [1:0] OpHalt  = 2'b11;

  typedef enum logic [1:0] {StIdle, StRun, StWait, StDone} state_e;

  state_e             state_q, state_d;
  logic [OUT_W-1:0]   stim_q, stim_d;
  logic               obs_q, obs_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic               loop_act_q, loop_act_d;
  logic [CNT_W-1:0]   loop_cnt_q, loop_cnt_d;
  logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;

  logic [OUT_W+2:0]   mem_q [DEPTH];
  logic [OUT_W+2:0]   word;
  logic [1:0]         op;
  logic               obs_bit;
  logic [OUT_W-1:0]   pay;
  logic [CNT_W-1:0]   wait_n;
  logic [ADDR_W-1:0]  loop_t;
  logic [CNT_W-1:0]   loop_c;
  logic [ADDR_W-1:0]  pc_inc;

  assign word    = mem_q[pc_q];
  assign op      = word[OUT_W+2:OUT_W+1];
  assign obs_bit = word[OUT_W];
  assign pay     = word[OUT_W-1:0];
  assign wait_n  = pay[CNT_W-1:0];
  assign loop_t  = pay[ADDR_W-1:0];
  assign loop_c  = pay[ADDR_W+CNT_W-1:ADDR_W];
  // Explicit wrap so non-power-of-two depths never address past the array.
  assign pc_inc  = (pc_q == AddrMax) ? '0 : pc_q + 1'b1;

  // Program array is not reset; writes are locked out while a program runs.
  always_ff @(posedge wb_clk_i) begin
    if (ld_we_i && (state_q == StIdle || state_q == StDone)) begin
      mem_q[ld_addr_i] <= ld_data_i;
    end
  end

  always_comb begin
    state_d    = state_q;
    stim_d     = stim_q;
    obs_d      = obs_q;
    pc_d       = pc_q;
    loop_act_d = loop_act_q;
    loop_cnt_d = loop_cnt_q;
    wait_cnt_d = wait_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d = StRun;
          pc_d    = '0;
        end
      end
      StDone: begin
        if (start_i) begin
          state_d    = StRun;
          pc_d       = '0;
          loop_act_d = 1'b0;
        end
      end
      StRun: begin
        if (stop_i) begin
          state_d    = StIdle;
          pc_d       = '0;
          loop_act_d = 1'b0;
          obs_d      = 1'b0;
        end else begin
          unique case (op)
            OpDrive: begin
              stim_d = pay;
              obs_d  = obs_bit;
              pc_d   = pc_inc;
            end
            OpWait: begin
              obs_d = 1'b0;
              if (wait_n == '0) begin
                pc_d = pc_inc;
              end else begin
                state_d    = StWait;
                wait_cnt_d = wait_n - 1'b1;
              end
            end
            OpLoop: begin
              obs_d = 1'b0;
              if (!loop_act_q) begin
                if (loop_c == '0) begin
                  pc_d = pc_inc;
                end else begin
                  loop_act_d = 1'b1;
                  loop_cnt_d = loop_c - 1'b1;
                  pc_d       = loop_t;
                end
              end else if (loop_cnt_q == '0) begin
                loop_act_d = 1'b0;
                pc_d       = pc_inc;
              end else begin
                loop_cnt_d = loop_cnt_q - 1'b1;
                pc_d       = loop_t;
              end
            end
            OpHalt: begin
              state_d = StDone;
              obs_d   = 1'b0;
            end
            default: state_d = StIdle;
          endcase
        end
      end
      StWait: begin
        if (stop_i) begin
          state_d    = StIdle;
          pc_d       = '0;
          loop_act_d = 1'b0;
          obs_d      = 1'b0;
        end else if (wait_cnt_q == '0) begin
          state_d = StRun;
          pc_d    = pc_inc;
        end else begin
          wait_cnt_d = wait_cnt_q - 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (!rst_i) begin
      state_q    <= StIdle;
      stim_q     <= '0;
      obs_q      <= 1'b0;
      pc_q       <= '0;
      loop_act_q <= 1'b0;
      loop_cnt_q <= '0;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      stim_q     <= stim_d;
      obs_q      <= obs_d;
      pc_q       <= pc_d;
      loop_act_q <= loop_act_d;
      loop_cnt_q <= loop_cnt_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  assign stim_o = stim_q;
  assign obs_o  = obs_q;
  assign pc_o   = pc_q;
  assign busy_o = (state_q == StRun) || (state_q == StWait);
  assign done_o = (state_q == StDone);

`ifdef STIM_TRACE_EN
  logic              retire;
  logic              trace_vld_q;
  logic [ADDR_W-1:0] trace_pc_q;

  // A WAIT with N>0 retires on its exit cycle, not on entry.
  assign retire = !stop_i &&
                  ((state_q == StRun && !(op == OpWait && wait_n != '0)) ||
                   (state_q == StWait && wait_cnt_q == '0));

  always_ff @(posedge wb_clk_i) begin
    if (!rst_i) begin
      trace_vld_q <= 1'b0;
      trace_pc_q  <= '0;
    end else begin
      trace_vld_q <= retire;
      trace_pc_q  <= pc_q;
    end
  end

  assign trace_vld_o = trace_vld_q;
  assign trace_pc_o  = trace_pc_q;
`endif

endmodule

// File: tb/tb_stim_sequencer.sv
// Directed self-checking bench for stim_sequencer (reset, DRIVE, WAIT, LOOP, control, optional trace).
module tb_stim_sequencer;
  localparam int OUT_W  = 16;
  localparam int DEPTH  = 32;
  localparam int CNT_W  = 8;
  localparam int ADDR_W = 5;
  localparam int W      = OUT_W + 3;

  logic              clk = 1'b0;
  logic              rst, ld_we, start, stop;
  logic [ADDR_W-1:0] ld_addr;
  logic [W-1:0]      ld_data;
  logic [OUT_W-1:0]  stim;
  logic              obs, busy, done;
  logic [ADDR_W-1:0] pc;
`ifdef STIM_TRACE_EN
  logic              trace_vld;
  logic [ADDR_W-1:0] trace_pc;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  stim_sequencer #(.OUT_W(OUT_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .wb_clk_i  (clk),
    .rst_i     (rst),
    .ld_we_i   (ld_we),
    .ld_addr_i (ld_addr),
    .ld_data_i (ld_data),
    .start_i   (start),
    .stop_i    (stop),
    .stim_o    (stim),
    .obs_o     (obs),
    .pc_o      (pc),
    .busy_o    (busy),
    .done_o    (done)
`ifdef STIM_TRACE_EN
    ,
    .trace_vld_o (trace_vld),
    .trace_pc_o  (trace_pc)
`endif
  );

  function automatic logic [W-1:0] drv(input logic obs_b, input logic [OUT_W-1:0] p);
    return {2'b00, obs_b, p};
  endfunction

  function automatic logic [W-1:0] wt(input int n);
    logic [OUT_W-1:0] p;
    p = '0;
    p[CNT_W-1:0] = n[CNT_W-1:0];
    return {2'b01, 1'b0, p};
  endfunction

  function automatic logic [W-1:0] lp(input int t, input int c);
    logic [OUT_W-1:0] p;
    p = '0;
    p[ADDR_W-1:0] = t[ADDR_W-1:0];
    p[ADDR_W+CNT_W-1:ADDR_W] = c[CNT_W-1:0];
    return {2'b10, 1'b0, p};
  endfunction

  function automatic logic [W-1:0] hlt();
    return {2'b11, 1'b0, {OUT_W{1'b0}}};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int a, input logic [W-1:0] d);
    ld_we   = 1'b1;
    ld_addr = a[ADDR_W-1:0];
    ld_data = d;
    tick();
    ld_we   = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0; start = 1'b0; stop = 1'b0; ld_we = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic run_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    load(0, hlt());
    rst = 1'b0; start = 1'b1;
    tick();
    tick();
    n_checks++; if (stim !== 16'h0) begin n_fail++; $display("FAIL reset_stim: got %h want 0000", stim); end
    n_checks++; if (obs !== 1'b0) begin n_fail++; $display("FAIL reset_obs: got %b want 0", obs); end
    n_checks++; if (pc !== 5'd0) begin n_fail++; $display("FAIL reset_pc: got %0d want 0", pc); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
    rst = 1'b1;
    tick();
    start = 1'b0;
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL reset_release_busy: got %b want 1", busy); end
    tick();
    n_checks++; if (done !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_halt: got done=%b busy=%b want done=1 busy=0", done, busy);
    end
  endtask

  task automatic test_drive();
    do_reset();
    load(0, drv(1'b1, 16'h00A5));
    load(1, drv(1'b0, 16'h1234));
    load(2, hlt());
    run_start();
    n_checks++; if (busy !== 1'b1 || stim !== 16'h0) begin
      n_fail++; $display("FAIL drive_start: got busy=%b stim=%h want busy=1 stim=0000", busy, stim);
    end
    tick();
    n_checks++; if (stim !== 16'h00A5 || obs !== 1'b1 || pc !== 5'd1) begin
      n_fail++; $display("FAIL drive_w0: got stim=%h obs=%b pc=%0d want 00a5 1 1", stim, obs, pc);
    end
    tick();
    n_checks++; if (stim !== 16'h1234 || obs !== 1'b0 || pc !== 5'd2) begin
      n_fail++; $display("FAIL drive_w1: got stim=%h obs=%b pc=%0d want 1234 0 2", stim, obs, pc);
    end
    tick();
    n_checks++; if (done !== 1'b1 || busy !== 1'b0 || stim !== 16'h1234 || pc !== 5'd2) begin
      n_fail++; $display("FAIL drive_halt: got done=%b busy=%b stim=%h pc=%0d want 1 0 1234 2",
                         done, busy, stim, pc);
    end
  endtask

  task automatic test_wait();
    do_reset();
    load(0, drv(1'b1, 16'h0001));
    load(1, wt(3));
    load(2, drv(1'b0, 16'h0002));
    load(3, hlt());
    run_start();
    tick();
    // Word 0 output plus the four cycles the WAIT word occupies.
    for (int i = 0; i < 5; i++) begin
      n_checks++; if (stim !== 16'h0001 || busy !== 1'b1) begin
        n_fail++; $display("FAIL wait3_hold[%0d]: got stim=%h busy=%b want 0001 1", i, stim, busy);
      end
      if (i > 0) begin
        n_checks++; if (obs !== 1'b0) begin n_fail++; $display("FAIL wait3_obs[%0d]: got %b want 0", i, obs); end
      end
      tick();
    end
    n_checks++; if (stim !== 16'h0002 || pc !== 5'd3) begin
      n_fail++; $display("FAIL wait3_after: got stim=%h pc=%0d want 0002 3", stim, pc);
    end

    do_reset();
    load(1, wt(0));
    run_start();
    tick();
    tick();
    n_checks++; if (stim !== 16'h0001 || pc !== 5'd2) begin
      n_fail++; $display("FAIL wait0_nop: got stim=%h pc=%0d want 0001 2", stim, pc);
    end
    tick();
    n_checks++; if (stim !== 16'h0002) begin n_fail++; $display("FAIL wait0_after: got %h want 0002", stim); end
  endtask

  task automatic test_loop();
    logic [OUT_W-1:0]  e_stim [10];
    logic [ADDR_W-1:0] e_pc   [10];
    logic [ADDR_W-1:0] e_tpc  [10];
    e_stim = '{16'h1, 16'h2, 16'h2, 16'h1, 16'h2, 16'h2, 16'h1, 16'h2, 16'h2, 16'h2};
    e_pc   = '{5'd1, 5'd2, 5'd0, 5'd1, 5'd2, 5'd0, 5'd1, 5'd2, 5'd3, 5'd3};
    e_tpc  = '{5'd0, 5'd1, 5'd2, 5'd0, 5'd1, 5'd2, 5'd0, 5'd1, 5'd2, 5'd3};
    do_reset();
    load(0, drv(1'b0, 16'h0001));
    load(1, drv(1'b0, 16'h0002));
    load(2, lp(0, 2));
    load(3, hlt());
    run_start();
    for (int i = 0; i < 10; i++) begin
      tick();
      n_checks++; if (stim !== e_stim[i] || pc !== e_pc[i]) begin
        n_fail++; $display("FAIL loop_step[%0d]: got stim=%h pc=%0d want %h %0d", i, stim, pc, e_stim[i], e_pc[i]);
      end
`ifdef STIM_TRACE_EN
      n_checks++; if (trace_vld !== 1'b1 || trace_pc !== e_tpc[i]) begin
        n_fail++; $display("FAIL trace_step[%0d]: got vld=%b pc=%0d want 1 %0d", i, trace_vld, trace_pc, e_tpc[i]);
      end
`endif
    end
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL loop_done: got %b want 1", done); end
`ifdef STIM_TRACE_EN
    tick();
    n_checks++; if (trace_vld !== 1'b0) begin n_fail++; $display("FAIL trace_idle: got %b want 0", trace_vld); end
`endif

    do_reset();
    load(2, lp(0, 0));
    run_start();
    for (int i = 0; i < 4; i++) tick();
    n_checks++; if (done !== 1'b1 || pc !== 5'd3 || stim !== 16'h0002) begin
      n_fail++; $display("FAIL loop_c0: got done=%b pc=%0d stim=%h want 1 3 0002", done, pc, stim);
    end
  endtask

  task automatic test_control();
    // stop_i mid-WAIT
    do_reset();
    load(0, wt(5));
    load(1, hlt());
    run_start();
    tick();
    tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    n_checks++; if (busy !== 1'b0 || done !== 1'b0 || pc !== 5'd0) begin
      n_fail++; $display("FAIL stop_wait: got busy=%b done=%b pc=%0d want 0 0 0", busy, done, pc);
    end

    // load ignored while busy
    load(0, drv(1'b0, 16'h0011));
    load(1, wt(3));
    load(2, drv(1'b0, 16'h0022));
    load(3, hlt());
    run_start();
    tick();
    tick();
    load(2, drv(1'b0, 16'h0BAD));
    tick();
    tick();
    tick();
    n_checks++; if (stim !== 16'h0022) begin n_fail++; $display("FAIL load_busy: got %h want 0022", stim); end
    tick();
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL load_busy_done: got %b want 1", done); end

    // restart from DONE
    run_start();
    n_checks++; if (busy !== 1'b1 || done !== 1'b0 || pc !== 5'd0) begin
      n_fail++; $display("FAIL restart: got busy=%b done=%b pc=%0d want 1 0 0", busy, done, pc);
    end
    tick();
    n_checks++; if (stim !== 16'h0011 || pc !== 5'd1) begin
      n_fail++; $display("FAIL restart_w0: got stim=%h pc=%0d want 0011 1", stim, pc);
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;

    // pc wrap from DEPTH-1 to 0
    load(0, lp(31, 1));
    load(1, hlt());
    load(31, drv(1'b1, 16'h0777));
    run_start();
    tick();
    n_checks++; if (pc !== 5'd31) begin n_fail++; $display("FAIL wrap_jump: got pc=%0d want 31", pc); end
    tick();
    n_checks++; if (stim !== 16'h0777 || obs !== 1'b1 || pc !== 5'd0) begin
      n_fail++; $display("FAIL wrap_pc: got stim=%h obs=%b pc=%0d want 0777 1 0", stim, obs, pc);
    end
    tick();
    tick();
    n_checks++; if (done !== 1'b1 || pc !== 5'd1) begin
      n_fail++; $display("FAIL wrap_halt: got done=%b pc=%0d want 1 1", done, pc);
    end
  endtask

  initial begin
    rst = 1'b0; ld_we = 1'b0; start = 1'b0; stop = 1'b0;
    ld_addr = '0; ld_data = '0;
    test_reset();
    test_drive();
    test_wait();
    test_loop();
    test_control();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
